trail_iir_stream: RTL and testbench

Parametrised successor of the single-mode RGB trail filter: per-pixel combination of a history (framebuffer) pixel and a camera pixel.
- Generalised in channel count, channel width and decay precision.
- Four runtime modes; decay and threshold set at runtime and latched per frame.
- valid/ready backpressure with a fixed 3-stage pipeline.
- Per-frame trail-pixel statistics counter.
- Sits between the camera/framebuffer read merge and the framebuffer write-back.

---
 rtl/trail_iir_stream.sv | 224 ++++++++++++++++++++++
 tb/tb_trail_iir_stream.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trail_iir_stream.sv
// Trail filter stream stage: merges a history pixel and a camera pixel under one of
// four runtime modes, in a 3-stage valid/ready pipeline with a per-frame hit counter.
module trail_iir_stream #(
    parameter int                   CHANNELS      = 3,
    parameter int                   CH_WIDTH      = 8,
    parameter int                   FRAC_BITS     = 16,
    parameter logic [FRAC_BITS-1:0] DEFAULT_DECAY = 16'hFAE1,
    parameter int                   COUNT_WIDTH   = 24
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [1:0]                   mode_in,
    input  logic [CH_WIDTH-1:0]          threshold_in,
    input  logic [FRAC_BITS-1:0]         decay_in,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_sof,
    input  logic                         in_eof,
    input  logic [CHANNELS*CH_WIDTH-1:0] history_in,
    input  logic [CHANNELS*CH_WIDTH-1:0] camera_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_sof,
    output logic                         out_eof,
    output logic [CHANNELS*CH_WIDTH-1:0] update_out,
    output logic [COUNT_WIDTH-1:0]       trail_count_out,
    output logic                         count_valid_out
);
    localparam int W  = CH_WIDTH;
    localparam int F  = FRAC_BITS;
    localparam int PW = CHANNELS * CH_WIDTH;
    localparam int MW = CH_WIDTH + FRAC_BITS + 1;
    localparam int YW = CH_WIDTH + 9;

    localparam logic [1:0] MODE_PASS      = 2'd0;
    localparam logic [1:0] MODE_MASK      = 2'd1;
    localparam logic [1:0] MODE_MAX_TRAIL = 2'd2;
    localparam logic [1:0] MODE_BLEND     = 2'd3;

    // Handshake: a transfer happens on a rising edge where valid && ready. Every stage
    // advances together on en, so a stalled output freezes the whole pipe and in_ready drops.
    logic en;
    logic accept;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && en;

    logic [1:0]   cfg_mode, eff_mode;
    logic [W-1:0] cfg_thr, eff_thr;
    logic [F-1:0] cfg_decay, eff_decay;
    logic         take_cfg;

    // The sof pixel itself already runs with the freshly presented configuration.
    assign take_cfg  = in_valid && in_sof;
    assign eff_mode  = take_cfg ? mode_in      : cfg_mode;
    assign eff_thr   = take_cfg ? threshold_in : cfg_thr;
    assign eff_decay = take_cfg ? decay_in     : cfg_decay;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cfg_mode  <= MODE_PASS;
            cfg_thr   <= '0;
            cfg_decay <= DEFAULT_DECAY;
        end else if (accept && in_sof) begin
            cfg_mode  <= mode_in;
            cfg_thr   <= threshold_in;
            cfg_decay <= decay_in;
        end
    end

    logic          s1_valid, s1_sof, s1_eof;
    logic [1:0]    s1_mode;
    logic [W-1:0]  s1_thr;
    logic [F-1:0]  s1_decay;
    logic [PW-1:0] s1_hist, s1_cam;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            s1_valid <= 1'b0;
            s1_sof   <= 1'b0;
            s1_eof   <= 1'b0;
            s1_mode  <= MODE_PASS;
            s1_thr   <= '0;
            s1_decay <= '0;
            s1_hist  <= '0;
            s1_cam   <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_sof   <= in_valid && in_sof;
            s1_eof   <= in_valid && in_eof;
            s1_mode  <= eff_mode;
            s1_thr   <= eff_thr;
            s1_decay <= eff_decay;
            s1_hist  <= history_in;
            s1_cam   <= camera_in;
        end
    end

    logic [W-1:0] yh, yc;

    if (CHANNELS == 3) begin : g_luma_rgb
        logic [YW-1:0] sum_h, sum_c;
        assign sum_h = YW'(77) * YW'(s1_hist[3*W-1:2*W]) + YW'(150) * YW'(s1_hist[2*W-1:W])
                     + YW'(29) * YW'(s1_hist[W-1:0]);
        assign sum_c = YW'(77) * YW'(s1_cam[3*W-1:2*W]) + YW'(150) * YW'(s1_cam[2*W-1:W])
                     + YW'(29) * YW'(s1_cam[W-1:0]);
        assign yh = W'(sum_h >> 8);
        assign yc = W'(sum_c >> 8);
    end else begin : g_luma_mono
        assign yh = s1_hist;
        assign yc = s1_cam;
    end

    logic [PW-1:0] dec_px, blend_px;

    // Full-width products; the weighted sum never exceeds (2^W-1)*2^F, so truncation is exact.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [MW-1:0] h, c, inv, hd, bl;
        assign h   = MW'(s1_hist[i*W +: W]);
        assign c   = MW'(s1_cam[i*W +: W]);
        assign inv = (MW'(1) << F) - MW'(s1_decay);
        assign hd  = h * MW'(s1_decay);
        assign bl  = hd + c * inv;
        assign dec_px[i*W +: W]   = W'(hd >> F);
        assign blend_px[i*W +: W] = W'(bl >> F);
    end

    logic          s2_valid, s2_sof, s2_eof;
    logic [1:0]    s2_mode;
    logic [W-1:0]  s2_thr, s2_yh, s2_yc;
    logic [PW-1:0] s2_cam, s2_dec, s2_blend;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            s2_valid <= 1'b0;
            s2_sof   <= 1'b0;
            s2_eof   <= 1'b0;
            s2_mode  <= MODE_PASS;
            s2_thr   <= '0;
            s2_yh    <= '0;
            s2_yc    <= '0;
            s2_cam   <= '0;
            s2_dec   <= '0;
            s2_blend <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_sof   <= s1_sof;
            s2_eof   <= s1_eof;
            s2_mode  <= s1_mode;
            s2_thr   <= s1_thr;
            s2_yh    <= yh;
            s2_yc    <= yc;
            s2_cam   <= s1_cam;
            s2_dec   <= dec_px;
            s2_blend <= blend_px;
        end
    end

    logic [PW-1:0] sel_px;
    logic          sel_hit;

    always_comb begin
        sel_px  = s2_cam;
        sel_hit = 1'b0;
        case (s2_mode)
            MODE_MASK: begin
                sel_hit = s2_yc > s2_thr;
                sel_px  = sel_hit ? s2_cam : '0;
            end
            MODE_MAX_TRAIL: begin
                sel_hit = (s2_yh > s2_yc) && (s2_yh > s2_thr);
                sel_px  = sel_hit ? s2_dec : s2_cam;
            end
            MODE_BLEND: sel_px = s2_blend;
            default: ;
        endcase
    end

    logic out_hit;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            out_eof    <= 1'b0;
            update_out <= '0;
            out_hit    <= 1'b0;
        end else if (en) begin
            out_valid  <= s2_valid;
            out_sof    <= s2_sof;
            out_eof    <= s2_eof;
            update_out <= sel_px;
            out_hit    <= s2_valid && sel_hit;
        end
    end

    logic [COUNT_WIDTH-1:0] run_count, count_base, count_next;

    // An sof restarts the count even when the previous frame never delivered its eof.
    always_comb begin
        count_base = out_sof ? '0 : run_count;
        count_next = count_base;
        if (out_hit && (count_base != '1)) count_next = count_base + COUNT_WIDTH'(1);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            run_count       <= '0;
            trail_count_out <= '0;
            count_valid_out <= 1'b0;
        end else begin
            count_valid_out <= 1'b0;
            if (out_valid && out_ready) begin
                if (out_eof) begin
                    trail_count_out <= count_next;
                    count_valid_out <= 1'b1;
                    run_count       <= '0;
                end else begin
                    run_count <= count_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_trail_iir_stream.sv
// Directed bench for trail_iir_stream: modes, latency, backpressure, config latch,
// per-frame trail counting and asynchronous reset under stall.
module tb_trail_iir_stream;
    localparam int W  = 8;
    localparam int F  = 16;
    localparam int CW = 24;
    localparam int PW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode_in;
    logic [W-1:0]  threshold_in;
    logic [F-1:0]  decay_in;
    logic          in_valid, in_ready, in_sof, in_eof;
    logic [PW-1:0] history_in, camera_in;
    logic          out_valid, out_ready, out_sof, out_eof;
    logic [PW-1:0] update_out;
    logic [CW-1:0] trail_count_out;
    logic          count_valid_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    trail_iir_stream dut (
        .clk_in(clk), .rst_in(rst), .mode_in(mode_in), .threshold_in(threshold_in),
        .decay_in(decay_in), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
        .in_eof(in_eof), .history_in(history_in), .camera_in(camera_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof), .out_eof(out_eof),
        .update_out(update_out), .trail_count_out(trail_count_out),
        .count_valid_out(count_valid_out)
    );

    // Output monitor used by the frame-level tests (out_ready held high while enabled).
    logic          mon_en = 1'b0;
    logic [PW-1:0] res_q[$];
    int            cyc = 0;
    int            eof_cyc = -1;
    int            pulse_cyc = -1;
    int            pulses = 0;
    logic [CW-1:0] pulse_val = '0;

    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (mon_en) begin
            if (out_valid && out_ready) begin
                res_q.push_back(update_out);
                if (out_eof) eof_cyc = cyc;
            end
            if (count_valid_out) begin
                pulses++;
                pulse_cyc = cyc;
                pulse_val = trail_count_out;
            end
        end
    end

    function automatic logic [PW-1:0] px3(input logic [7:0] v);
        return {v, v, v};
    endfunction

    function automatic logic [PW-1:0] spix(input int i);
        int a, b, c;
        a = i * 7 + 1;
        b = 255 - i;
        c = i * 13;
        return {a[7:0], b[7:0], c[7:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eof   = 1'b0;
    endtask

    logic [PW-1:0] fr_hist[16];
    logic [PW-1:0] fr_cam[16];

    task automatic push_frame(input int n, input bit with_sof, input int change_at,
                              input logic [1:0] alt_mode, input logic [F-1:0] alt_decay);
        res_q.delete();
        pulses    = 0;
        eof_cyc   = -1;
        pulse_cyc = -1;
        out_ready = 1'b1;
        mon_en    = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (i == change_at) begin
                mode_in  = alt_mode;
                decay_in = alt_decay;
            end
            in_valid   = 1'b1;
            in_sof     = with_sof && (i == 0);
            in_eof     = (i == n - 1);
            history_in = fr_hist[i];
            camera_in  = fr_cam[i];
            tick();
        end
        idle();
        for (int i = 0; i < 6; i++) tick();
        mon_en = 1'b0;
    endtask

    task automatic run_one(input logic [1:0] m, input logic [7:0] thr, input logic [F-1:0] d,
                           input logic [PW-1:0] h, input logic [PW-1:0] c,
                           output logic [PW-1:0] r, output logic ok);
        mode_in = m; threshold_in = thr; decay_in = d; out_ready = 1'b1;
        in_valid = 1'b1; in_sof = 1'b1; in_eof = 1'b1; history_in = h; camera_in = c;
        tick();
        idle();
        ok = 1'b0;
        r  = '0;
        for (int i = 0; i < 6 && !ok; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                r  = update_out;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (update_out !== '0) begin n_bad++; $display("FAIL reset_update got %h want 0", update_out); end
        n_cmp++; if ({out_sof, out_eof} !== 2'b00) begin n_bad++; $display("FAIL reset_sof_eof got %b want 00", {out_sof, out_eof}); end
        n_cmp++; if (trail_count_out !== '0) begin n_bad++; $display("FAIL reset_count got %0d want 0", trail_count_out); end
        n_cmp++; if (count_valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_count_valid got %b want 0", count_valid_out); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_max_trail();
        mode_in = 2; threshold_in = 100; decay_in = 16'hFAE1; out_ready = 1'b1;
        in_valid = 1'b1; in_sof = 1'b1; in_eof = 1'b1;
        history_in = px3(200); camera_in = px3(50);
        tick();
        idle();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL lat_cycle1 out_valid got %b want 0", out_valid); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL lat_cycle2 out_valid got %b want 0", out_valid); end
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL lat_cycle3 out_valid got %b want 1", out_valid); end
        n_cmp++; if (update_out !== px3(195)) begin n_bad++; $display("FAIL max_trail_px got %h want %h", update_out, px3(195)); end
        n_cmp++; if ({out_sof, out_eof} !== 2'b11) begin n_bad++; $display("FAIL max_trail_sof_eof got %b want 11", {out_sof, out_eof}); end
        tick();
        n_cmp++; if (count_valid_out !== 1'b1) begin n_bad++; $display("FAIL single_pulse got %b want 1", count_valid_out); end
        n_cmp++; if (trail_count_out !== 24'd1) begin n_bad++; $display("FAIL single_count got %0d want 1", trail_count_out); end
        tick();
        n_cmp++; if (count_valid_out !== 1'b0) begin n_bad++; $display("FAIL single_pulse_width got %b want 0", count_valid_out); end
    endtask

    task automatic test_blend_mask();
        logic [1:0]    t_mode[8];
        logic [7:0]    t_thr[8];
        logic [F-1:0]  t_dec[8];
        logic [PW-1:0] t_h[8], t_c[8], t_exp[8];
        logic [PW-1:0] r;
        logic          ok;
        t_mode = '{2'd3, 2'd3, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd3};
        t_thr  = '{8'd0, 8'd0, 8'd100, 8'd100, 8'd118, 8'd117, 8'd0, 8'd0};
        t_dec  = '{16'h8000, 16'h0000, 16'hFAE1, 16'hFAE1, 16'hFAE1, 16'hFAE1, 16'hFAE1, 16'h4000};
        t_h    = '{px3(200), px3(200), px3(0), px3(0), px3(0), px3(0), px3(200), {8'd100, 8'd0, 8'd255}};
        t_c    = '{px3(50), px3(50), px3(120), px3(90), {8'd200, 8'd100, 8'd0}, {8'd200, 8'd100, 8'd0},
                   {8'd1, 8'd2, 8'd3}, {8'd0, 8'd200, 8'd255}};
        t_exp  = '{px3(125), px3(50), px3(120), px3(0), px3(0), {8'd200, 8'd100, 8'd0},
                   {8'd1, 8'd2, 8'd3}, {8'd25, 8'd150, 8'd255}};
        for (int i = 0; i < 8; i++) begin
            run_one(t_mode[i], t_thr[i], t_dec[i], t_h[i], t_c[i], r, ok);
            n_cmp++;
            if (!ok || r !== t_exp[i]) begin
                n_bad++;
                $display("FAIL mode_vec%0d got %h (seen=%b) want %h", i, r, ok, t_exp[i]);
            end
        end
    endtask

    task automatic test_stream(input bit stall);
        logic [PW-1:0] exp_q[$];
        logic [PW-1:0] held, expv;
        logic          held_v, acc;
        int            idx, got, first_cyc, last_cyc;
        mode_in = 0; idx = 0; got = 0; held = '0; held_v = 1'b0; first_cyc = -1; last_cyc = -1;
        for (int c = 0; c < 100 && got < 20; c++) begin
            out_ready = !(stall && c >= 8 && c < 13);
            if (idx < 20) begin
                in_valid = 1'b1; in_sof = (idx == 0); in_eof = (idx == 19);
                camera_in = spix(idx); history_in = '0;
            end else begin
                idle();
            end
            #1;
            if (!out_ready) begin
                n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready c=%0d got %b want 0", c, in_ready); end
                if (held_v) begin
                    n_cmp++; if (update_out !== held) begin n_bad++; $display("FAIL stall_hold c=%0d got %h want %h", c, update_out, held); end
                end
            end
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                if (first_cyc < 0) first_cyc = c;
                last_cyc = c;
                expv = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                n_cmp++; if (update_out !== expv) begin n_bad++; $display("FAIL stream_px%0d got %h want %h", got, update_out, expv); end
                got++;
            end
            held   = update_out;
            held_v = out_valid && !out_ready;
            if (acc) begin
                exp_q.push_back(spix(idx));
                idx++;
            end
            tick();
        end
        idle();
        out_ready = 1'b1;
        n_cmp++; if (got != 20) begin n_bad++; $display("FAIL stream_count got %0d want 20", got); end
        n_cmp++; if (first_cyc != 3) begin n_bad++; $display("FAIL stream_first got %0d want 3", first_cyc); end
        n_cmp++;
        if (last_cyc - first_cyc != (stall ? 24 : 19)) begin
            n_bad++; $display("FAIL stream_span got %0d want %0d", last_cyc - first_cyc, stall ? 24 : 19);
        end
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_config_latch();
        for (int i = 0; i < 8; i++) begin fr_hist[i] = px3(200); fr_cam[i] = px3(50); end
        mode_in = 2; threshold_in = 100; decay_in = 16'hFAE1;
        push_frame(8, 1'b1, 5, 2'd0, 16'h8000);
        n_cmp++; if (res_q.size() != 8) begin n_bad++; $display("FAIL cfg_f1_len got %0d want 8", res_q.size()); end
        for (int i = 0; i < res_q.size(); i++) begin
            n_cmp++; if (res_q[i] !== px3(195)) begin n_bad++; $display("FAIL cfg_f1_px%0d got %h want %h", i, res_q[i], px3(195)); end
        end
        push_frame(4, 1'b1, 2, 2'd2, 16'hFAE1);
        n_cmp++; if (res_q.size() != 4) begin n_bad++; $display("FAIL cfg_f2_len got %0d want 4", res_q.size()); end
        for (int i = 0; i < res_q.size(); i++) begin
            n_cmp++; if (res_q[i] !== px3(50)) begin n_bad++; $display("FAIL cfg_f2_px%0d got %h want %h", i, res_q[i], px3(50)); end
        end
        mode_in = 2; decay_in = 16'h8000;
        push_frame(2, 1'b1, 1, 2'd0, 16'hFAE1);
        n_cmp++; if (res_q.size() != 2) begin n_bad++; $display("FAIL cfg_f3_len got %0d want 2", res_q.size()); end
        for (int i = 0; i < res_q.size(); i++) begin
            n_cmp++; if (res_q[i] !== px3(100)) begin n_bad++; $display("FAIL cfg_f3_px%0d got %h want %h", i, res_q[i], px3(100)); end
        end
    endtask

    task automatic test_trail_count();
        logic [PW-1:0] expv[16];
        for (int i = 0; i < 16; i++) begin
            fr_hist[i] = px3(10); fr_cam[i] = px3(60); expv[i] = px3(60);
        end
        fr_hist[1]  = px3(150); fr_cam[1]  = px3(150); expv[1]  = px3(150);
        fr_hist[3]  = px3(200); fr_cam[3]  = px3(50);  expv[3]  = px3(195);
        fr_hist[5]  = px3(100); fr_cam[5]  = px3(0);   expv[5]  = px3(0);
        fr_hist[7]  = px3(101); fr_cam[7]  = px3(0);   expv[7]  = px3(98);
        fr_hist[10] = px3(200); fr_cam[10] = px3(50);  expv[10] = px3(195);
        fr_hist[12] = px3(90);  fr_cam[12] = px3(20);  expv[12] = px3(20);
        fr_hist[15] = px3(200); fr_cam[15] = px3(50);  expv[15] = px3(195);
        mode_in = 2; threshold_in = 100; decay_in = 16'hFAE1;
        push_frame(16, 1'b1, -1, 2'd0, 16'h0);
        n_cmp++; if (res_q.size() != 16) begin n_bad++; $display("FAIL cnt_len got %0d want 16", res_q.size()); end
        for (int i = 0; i < res_q.size(); i++) begin
            n_cmp++; if (res_q[i] !== expv[i]) begin n_bad++; $display("FAIL cnt_px%0d got %h want %h", i, res_q[i], expv[i]); end
        end
        n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL cnt_pulses got %0d want 1", pulses); end
        n_cmp++; if (pulse_val !== 24'd4) begin n_bad++; $display("FAIL cnt_value got %0d want 4", pulse_val); end
        n_cmp++; if (pulse_cyc != eof_cyc + 1) begin n_bad++; $display("FAIL cnt_timing got %0d want %0d", pulse_cyc, eof_cyc + 1); end
        for (int i = 0; i < 4; i++) begin fr_hist[i] = px3(10); fr_cam[i] = px3(60); end
        push_frame(4, 1'b1, -1, 2'd0, 16'h0);
        n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL cnt0_pulses got %0d want 1", pulses); end
        n_cmp++; if (pulse_val !== 24'd0) begin n_bad++; $display("FAIL cnt0_value got %0d want 0", pulse_val); end
    endtask

    task automatic test_reset_stall();
        mode_in = 2; threshold_in = 100; decay_in = 16'hFAE1;
        fr_hist[0] = px3(200); fr_cam[0] = px3(50);
        push_frame(1, 1'b1, -1, 2'd0, 16'h0);
        n_cmp++; if (trail_count_out !== 24'd1) begin n_bad++; $display("FAIL pre_reset_count got %0d want 1", trail_count_out); end
        for (int c = 0; c < 8; c++) begin
            out_ready = (c < 4);
            in_valid = 1'b1; in_sof = (c == 0); in_eof = 1'b0;
            history_in = px3(200); camera_in = px3(50);
            tick();
        end
        idle();
        n_cmp++; if ({out_valid, in_ready} !== 2'b10) begin n_bad++; $display("FAIL stall_full got %b want 10", {out_valid, in_ready}); end
        n_cmp++; if (update_out !== px3(195)) begin n_bad++; $display("FAIL stall_px got %h want %h", update_out, px3(195)); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL async_out_valid got %b want 0", out_valid); end
        n_cmp++; if (update_out !== '0) begin n_bad++; $display("FAIL async_update got %h want 0", update_out); end
        n_cmp++; if ({out_sof, out_eof, count_valid_out} !== 3'b000) begin n_bad++; $display("FAIL async_flags got %b want 000", {out_sof, out_eof, count_valid_out}); end
        n_cmp++; if (trail_count_out !== '0) begin n_bad++; $display("FAIL async_count got %0d want 0", trail_count_out); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL async_in_ready got %b want 1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        fr_hist[0] = px3(200); fr_cam[0] = px3(50);
        fr_hist[1] = px3(200); fr_cam[1] = px3(50);
        push_frame(2, 1'b0, -1, 2'd0, 16'h0);
        n_cmp++; if (res_q.size() != 2) begin n_bad++; $display("FAIL post_nosof_len got %0d want 2", res_q.size()); end
        for (int i = 0; i < res_q.size(); i++) begin
            n_cmp++; if (res_q[i] !== px3(50)) begin n_bad++; $display("FAIL post_nosof_px%0d got %h want %h", i, res_q[i], px3(50)); end
        end
        n_cmp++; if (pulse_val !== 24'd0) begin n_bad++; $display("FAIL post_nosof_count got %0d want 0", pulse_val); end
        fr_hist[1] = px3(10); fr_cam[1] = px3(60);
        fr_hist[2] = px3(200); fr_cam[2] = px3(50);
        push_frame(3, 1'b1, -1, 2'd0, 16'h0);
        n_cmp++; if (res_q.size() != 3) begin n_bad++; $display("FAIL post_frame_len got %0d want 3", res_q.size()); end
        n_cmp++;
        if (res_q.size() == 3 && {res_q[0], res_q[1], res_q[2]} !== {px3(195), px3(60), px3(195)}) begin
            n_bad++; $display("FAIL post_frame_px got %h %h %h want %h %h %h", res_q[0], res_q[1], res_q[2], px3(195), px3(60), px3(195));
        end
        n_cmp++; if (pulse_val !== 24'd2) begin n_bad++; $display("FAIL post_frame_count got %0d want 2", pulse_val); end
    endtask

    initial begin
        rst = 1'b1; mode_in = 0; threshold_in = 0; decay_in = 16'hFAE1;
        in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        history_in = '0; camera_in = '0; out_ready = 1'b1;
        test_reset();
        test_max_trail();
        test_blend_mask();
        test_stream(1'b0);
        test_stream(1'b1);
        test_config_latch();
        test_trail_count();
        test_reset_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
